// File: rtl/aes_pkg.sv
// Shared AES byte-substitution tables, helpers and engine FSM state type.
// The inverse table is only consumed when SUB_BYTES_INV_EN is defined.
package aes_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [BYTE_W-1:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [BYTE_W-1:0] INV_SBOX [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  function automatic logic [BYTE_W-1:0] sbox_fwd(input logic [BYTE_W-1:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [BYTE_W-1:0] sbox_inv(input logic [BYTE_W-1:0] b);
    return INV_SBOX[b];
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// One combinational S-box lookup lane.
// The inverse ROM is only built when SUB_BYTES_INV_EN is defined.
module sbox_lane
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] val,
  input  logic              inv,
  output logic [BYTE_W-1:0] sub
);

`ifdef SUB_BYTES_INV_EN
  assign sub = inv ? sbox_inv(val) : sbox_fwd(val);
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign sub = sbox_fwd(val);
`endif

endmodule

// File: rtl/sub_bytes_engine.sv
// Multi-cycle SubBytes/SubWord engine, LANES bytes substituted per clock.
// Optional inverse substitution enabled by SUB_BYTES_INV_EN.
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int LANES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORDS*WORD_W-1:0] in_data,
  input  logic                    in_inv,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORDS*WORD_W-1:0] out_data,
  output logic                    busy
);

  localparam int NBYTES = WORDS * 4;
  localparam int NCHUNK = NBYTES / LANES;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (WORDS < 1 || WORDS > 8 || LANES < 1 || (NBYTES % LANES) != 0) begin : g_bad_cfg
    $error("sub_bytes_engine: illegal WORDS/LANES combination");
  end

  state_t                    state;
  logic [NBYTES*BYTE_W-1:0]  blk;
  logic [CW-1:0]             cnt;
  logic                      mode;
  logic [BYTE_W-1:0]         lane_in  [LANES];
  logic [BYTE_W-1:0]         lane_out [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = blk[(int'(cnt) * LANES + l) * BYTE_W +: BYTE_W];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_lane u_lane (
      .val (lane_in[l]),
      .inv (mode),
      .sub (lane_out[l])
    );
  end

`ifndef SUB_BYTES_INV_EN
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
  assign mode = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      blk       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
`ifdef SUB_BYTES_INV_EN
      mode      <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            blk   <= in_data;
            cnt   <= '0;
            state <= BUSY;
`ifdef SUB_BYTES_INV_EN
            mode  <= in_inv;
`endif
          end
        end
        BUSY: begin
          for (int l = 0; l < LANES; l++) begin
            blk[(int'(cnt) * LANES + l) * BYTE_W +: BYTE_W] <= lane_out[l];
          end
          // Counter parks on the last chunk; capture clears it again.
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);
  assign out_data = blk;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Self-checking bench for sub_bytes_engine over several WORDS/LANES builds.
// Reference S-box is derived from GF(2^8) inversion plus the affine map.
module tb_sub_bytes_engine;

  localparam int NCFG = 5;

  typedef struct {
    logic [31:0] d;
    logic        inv;
    logic [31:0] e;
  } vec_t;

  logic       clk;
  int         total;
  int         passed;
  int         ndone;
  vec_t       vecs [6];
  logic [7:0] ref_sbox [256];
  logic [7:0] ref_inv  [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cfg_w(input int g);
    case (g)
      0: return 1;
      1: return 4;
      2: return 4;
      3: return 3;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_l(input int g);
    case (g)
      0: return 4;
      1: return 1;
      2: return 2;
      3: return 6;
      default: return 16;
    endcase
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [255:0] exp_block(input logic [255:0] d,
                                             input logic inv, input int nb);
    logic [255:0] e = '0;
    logic use_inv;
`ifdef SUB_BYTES_INV_EN
    use_inv = inv;
`else
    use_inv = 1'b0 & inv;
`endif
    for (int j = 0; j < nb; j++) begin
      e[8*j +: 8] = use_inv ? ref_inv[d[8*j +: 8]] : ref_sbox[d[8*j +: 8]];
    end
    return e;
  endfunction

  task automatic check(input int g, input string nm,
                       input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL cfg%0d %s: got %h expected %h", g, nm, act, exp);
  endtask

  initial begin
    total = 0;
    passed = 0;
    ndone = 0;
    for (int a = 0; a < 256; a++) begin
      logic [7:0] b = 8'h00;
      for (int c = 1; c < 256; c++) begin
        if (gmul(8'(a), 8'(c)) == 8'h01) b = 8'(c);
      end
      ref_sbox[a] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    end
    for (int a = 0; a < 256; a++) ref_inv[ref_sbox[a]] = 8'(a);

    vecs[0] = '{32'h14DFF409, 1'b0, 32'hFA9EBF01};
`ifdef SUB_BYTES_INV_EN
    vecs[1] = '{32'hFA9EBF01, 1'b1, 32'h14DFF409};
    vecs[3] = '{32'h00000000, 1'b1, 32'h52525252};
    vecs[5] = '{32'h63636363, 1'b1, 32'h00000000};
`else
    vecs[1] = '{32'hFA9EBF01, 1'b1, 32'h2D0B087C};
    vecs[3] = '{32'h00000000, 1'b1, 32'h63636363};
    vecs[5] = '{32'h63636363, 1'b1, 32'hFBFBFBFB};
`endif
    vecs[2] = '{32'h00000000, 1'b0, 32'h63636363};
    vecs[4] = '{32'hFFFFFFFF, 1'b0, 32'h16161616};

    for (int c = 0; c < 50000 && ndone < NCFG; c++) @(posedge clk);
    if (ndone != NCFG) begin
      total++;
      $display("FAIL timeout: %0d of %0d configs finished", ndone, NCFG);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int W  = cfg_w(g);
    localparam int L  = cfg_l(g);
    localparam int NB = W * 4;
    localparam int NC = NB / L;

    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W*32-1:0] in_data;
    logic            in_inv;
    logic            out_valid;
    logic            out_ready;
    logic [W*32-1:0] out_data;
    logic            busy;

    sub_bytes_engine #(.WORDS(W), .LANES(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_inv    (in_inv),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
    );

    function automatic logic [W*32-1:0] rand_block();
      logic [W*32-1:0] r;
      for (int i = 0; i < W; i++) r[32*i +: 32] = $urandom;
      return r;
    endfunction

    task automatic run_block(input logic [W*32-1:0] d, input logic inv,
                             input logic [255:0] exp, input int bp,
                             input bit hold);
      int              lat;
      bit              ok;
      logic [W*32-1:0] snap;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_inv   = inv;
      @(posedge clk);
      #1;
      in_valid = hold;
      in_data  = rand_block();
      in_inv   = ~inv;
      ok  = 1'b1;
      lat = 0;
      while (!out_valid && lat < NC + 4) begin
        if (in_ready) ok = 1'b0;
        @(posedge clk);
        #1;
        lat++;
      end
      in_valid = 1'b0;
      check(g, "latency", 256'(lat), 256'(NC));
      check(g, "no_accept_busy", 256'(ok), 256'(1));
      check(g, "data", 256'(out_data), exp);
      snap = out_data;
      ok = 1'b1;
      repeat (bp) begin
        @(posedge clk);
        #1;
        if (!out_valid || out_data !== snap) ok = 1'b0;
      end
      check(g, "stall_stable", 256'(ok), 256'(1));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check(g, "after_handshake", 256'({out_valid, in_ready, busy}), 256'(3'b010));
    endtask

    initial begin
      int          k;
      logic [W*32-1:0] d;
      logic        inv;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_inv    = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check(g, "reset_flags", 256'({in_ready, out_valid, busy}), 256'(3'b000));
      check(g, "reset_data", 256'(out_data), 256'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check(g, "ready_after_reset", 256'(in_ready), 256'(1));

      for (int v = 0; v < 6; v++) begin
        run_block({W{vecs[v].d}}, vecs[v].inv,
                  256'({W{vecs[v].e}}), v % 3, v == 1);
      end

      // Reset while the block is still being substituted.
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = rand_block();
      in_inv   = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      k = (NC > 3) ? 3 : 0;
      repeat (k) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check(g, "midreset_flags", 256'({out_valid, busy, in_ready}), 256'(3'b000));
      check(g, "midreset_data", 256'(out_data), 256'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check(g, "midreset_idle", 256'(in_ready), 256'(1));
      d = rand_block();
      run_block(d, 1'b1, exp_block(256'(d), 1'b1, NB), 2, 1'b0);

      for (int r = 0; r < 25; r++) begin
        d   = rand_block();
        inv = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 2)) @(posedge clk);
        run_block(d, inv, exp_block(256'(d), inv, NB),
                  $urandom_range(0, 4), bit'($urandom_range(0, 1)));
      end
      ndone++;
    end
  end

endmodule
